// File: rtl/mult_pkg.sv
// Shared widths and FSM encoding for the multiplier datapath and its accumulator.
package mult_pkg;

  localparam int unsigned MULT_PROD_W = 17;
  localparam int unsigned MAC_ACC_W   = 24;
  localparam int unsigned MAC_CNT_W   = 5;

  typedef enum logic [1:0] {
    MAC_IDLE = 2'd0,
    MAC_RUN  = 2'd1,
    MAC_DONE = 2'd2
  } mac_state_e;

endpackage

// File: rtl/mac_accumulator_sat_add.sv
// Unsigned ACC_W-bit adder with zero-extended PROD_W addend; saturates on carry-out.
module mac_accumulator_sat_add
  import mult_pkg::*;
#(
  parameter int unsigned PROD_W = MULT_PROD_W,
  parameter int unsigned ACC_W  = MAC_ACC_W
) (
  input  logic [ACC_W-1:0]  a_i,
  input  logic [PROD_W-1:0] b_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              carry_o
);

  logic [ACC_W:0] wide_sum;

  always_comb begin
    wide_sum = {1'b0, a_i} + (ACC_W + 1)'(b_i);
    carry_o  = wide_sum[ACC_W];
    sum_o    = carry_o ? '1 : wide_sum[ACC_W-1:0];
  end

endmodule

// File: rtl/mac_accumulator.sv
// Accumulates a stream of unsigned products into one saturating sum per prod_last-terminated group.
module mac_accumulator
  import mult_pkg::*;
#(
  parameter int unsigned PROD_W = MULT_PROD_W,
  parameter int unsigned ACC_W  = MAC_ACC_W,
  parameter int unsigned CNT_W  = MAC_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_last,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc,
  output logic [CNT_W-1:0]  acc_count,
  output logic              acc_ovf
);

  mac_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] add_sum;
  logic             add_carry;
  logic             beat;

  mac_accumulator_sat_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_sat_add (
    .a_i     (acc_q),
    .b_i     (prod),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  always_comb begin
    prod_ready = (state_q != MAC_DONE);
    acc_valid  = (state_q == MAC_DONE);
    beat       = prod_valid && prod_ready;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      MAC_IDLE: begin
        if (beat) begin
          acc_d   = ACC_W'(prod);
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = prod_last ? MAC_DONE : MAC_RUN;
        end
      end
      MAC_RUN: begin
        if (beat) begin
          // Once overflowed the sum is pinned at all-ones regardless of later addends.
          ovf_d   = ovf_q || add_carry;
          acc_d   = ovf_d ? '1 : add_sum;
          cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          if (prod_last) state_d = MAC_DONE;
        end
      end
      MAC_DONE: begin
        if (acc_ready) state_d = MAC_IDLE;
      end
      default: state_d = MAC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MAC_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    acc       = acc_q;
    acc_count = cnt_q;
    acc_ovf   = ovf_q;
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed-vector bench for mac_accumulator with hand-computed expected sums.
module tb_mac_accumulator;

  localparam int unsigned PROD_W = 17;
  localparam int unsigned ACC_W  = 24;
  localparam int unsigned CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              prod_valid;
  logic              prod_ready;
  logic [PROD_W-1:0] prod;
  logic              prod_last;
  logic              acc_valid;
  logic              acc_ready;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  acc_count;
  logic              acc_ovf;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  mac_accumulator #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .prod       (prod),
    .prod_last  (prod_last),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .acc        (acc),
    .acc_count  (acc_count),
    .acc_ovf    (acc_ovf)
  );

  // Drive one cycle of stimulus, then settle just after the rising edge.
  task automatic cycle(input logic v, input logic [PROD_W-1:0] p, input logic l,
                       input logic ar);
    prod_valid = v;
    prod       = p;
    prod_last  = l;
    acc_ready  = ar;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    n_vec++;
    if ({acc_valid, prod_ready, acc_ovf, acc_count, acc} !== {1'b0, 1'b1, 1'b0, 5'd0, 24'd0}) begin
      n_err++;
      $display("FAIL reset: valid=%0b ready=%0b ovf=%0b cnt=%0d acc=%h, required 0 1 0 0 000000",
               acc_valid, prod_ready, acc_ovf, acc_count, acc);
    end
    rst_n = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_single();
    cycle(1'b1, 17'h0FE01, 1'b1, 1'b0);
    n_vec++;
    if ({acc_valid, prod_ready, acc_ovf, acc_count, acc} !== {1'b1, 1'b0, 1'b0, 5'd1, 24'h00FE01}) begin
      n_err++;
      $display("FAIL single: valid=%0b ready=%0b ovf=%0b cnt=%0d acc=%h, required 1 0 0 1 00fe01",
               acc_valid, prod_ready, acc_ovf, acc_count, acc);
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
    n_vec++;
    if ({acc_valid, prod_ready, acc_count, acc} !== {1'b0, 1'b1, 5'd1, 24'h00FE01}) begin
      n_err++;
      $display("FAIL single_hold_idle: valid=%0b ready=%0b cnt=%0d acc=%h, required 0 1 1 00fe01",
               acc_valid, prod_ready, acc_count, acc);
    end
  endtask

  task automatic test_four_beats();
    for (int i = 0; i < 4; i++) cycle(1'b1, 17'h0FE01, (i == 3), 1'b1);
    n_vec++;
    if ({acc_valid, acc_ovf, acc_count, acc} !== {1'b1, 1'b0, 5'd4, 24'h03F804}) begin
      n_err++;
      $display("FAIL four_beats: valid=%0b ovf=%0b cnt=%0d acc=%h, required 1 0 4 03f804",
               acc_valid, acc_ovf, acc_count, acc);
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
    n_vec++;
    if ({acc_valid, prod_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL four_beats_idle: valid=%0b ready=%0b, required 0 1", acc_valid, prod_ready);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 258; i++) cycle(1'b1, 17'h0FE01, 1'b0, 1'b0);
    n_vec++;
    if ({acc_valid, acc_ovf, acc_count, acc} !== {1'b0, 1'b0, 5'd31, 24'hFFFD02}) begin
      n_err++;
      $display("FAIL ovf_258: valid=%0b ovf=%0b cnt=%0d acc=%h, required 0 0 31 fffd02",
               acc_valid, acc_ovf, acc_count, acc);
    end
    cycle(1'b1, 17'h0FE01, 1'b1, 1'b0);
    n_vec++;
    if ({acc_valid, acc_ovf, acc_count, acc} !== {1'b1, 1'b1, 5'd31, 24'hFFFFFF}) begin
      n_err++;
      $display("FAIL ovf_259: valid=%0b ovf=%0b cnt=%0d acc=%h, required 1 1 31 ffffff",
               acc_valid, acc_ovf, acc_count, acc);
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
    // A fresh IDLE load must clear the sticky flag.
    cycle(1'b1, 17'h00002, 1'b1, 1'b0);
    n_vec++;
    if ({acc_ovf, acc_count, acc} !== {1'b0, 5'd1, 24'h000002}) begin
      n_err++;
      $display("FAIL ovf_clear: ovf=%0b cnt=%0d acc=%h, required 0 1 000002",
               acc_ovf, acc_count, acc);
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    cycle(1'b1, 17'h00010, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 17'h00100, 1'b1, 1'b0);
      n_vec++;
      if ({acc_valid, prod_ready, acc_count, acc} !== {1'b1, 1'b0, 5'd1, 24'h000010}) begin
        n_err++;
        $display("FAIL backpressure[%0d]: valid=%0b ready=%0b cnt=%0d acc=%h, required 1 0 1 000010",
                 i, acc_valid, prod_ready, acc_count, acc);
      end
    end
    cycle(1'b1, 17'h00100, 1'b1, 1'b1);
    cycle(1'b1, 17'h00007, 1'b1, 1'b0);
    n_vec++;
    if ({acc_valid, acc_count, acc} !== {1'b1, 5'd1, 24'h000007}) begin
      n_err++;
      $display("FAIL backpressure_next: valid=%0b cnt=%0d acc=%h, required 1 1 000007",
               acc_valid, acc_count, acc);
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 17'h0FE01, 1'b0, 1'b0);
    cycle(1'b1, 17'h0FE01, 1'b0, 1'b0);
    rst_n = 1'b0;
    cycle(1'b1, 17'h0FE01, 1'b0, 1'b1);
    rst_n = 1'b1;
    n_vec++;
    if ({acc_valid, prod_ready, acc_ovf, acc_count, acc} !== {1'b0, 1'b1, 1'b0, 5'd0, 24'd0}) begin
      n_err++;
      $display("FAIL reset_mid: valid=%0b ready=%0b ovf=%0b cnt=%0d acc=%h, required 0 1 0 0 000000",
               acc_valid, prod_ready, acc_ovf, acc_count, acc);
    end
    cycle(1'b1, 17'h00005, 1'b1, 1'b0);
    n_vec++;
    if ({acc_valid, acc_count, acc} !== {1'b1, 5'd1, 24'h000005}) begin
      n_err++;
      $display("FAIL reset_mid_next: valid=%0b cnt=%0d acc=%h, required 1 1 000005",
               acc_valid, acc_count, acc);
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_bubbles();
    cycle(1'b1, 17'h00001, 1'b0, 1'b0);
    cycle(1'b0, 17'h00001, 1'b1, 1'b0);
    n_vec++;
    if ({acc_valid, acc_count, acc} !== {1'b0, 5'd1, 24'h000001}) begin
      n_err++;
      $display("FAIL bubble_hold: valid=%0b cnt=%0d acc=%h, required 0 1 000001",
               acc_valid, acc_count, acc);
    end
    cycle(1'b1, 17'h00001, 1'b0, 1'b0);
    cycle(1'b0, 17'h00001, 1'b0, 1'b0);
    cycle(1'b1, 17'h00001, 1'b1, 1'b0);
    n_vec++;
    if ({acc_valid, acc_count, acc} !== {1'b1, 5'd3, 24'h000003}) begin
      n_err++;
      $display("FAIL bubbles: valid=%0b cnt=%0d acc=%h, required 1 3 000003",
               acc_valid, acc_count, acc);
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    // High-bit product exercises the full PROD_W width.
    cycle(1'b1, 17'h10000, 1'b0, 1'b1);
    cycle(1'b1, 17'h10000, 1'b1, 1'b1);
    n_vec++;
    if ({acc_valid, acc_count, acc} !== {1'b1, 5'd2, 24'h020000}) begin
      n_err++;
      $display("FAIL b2b_first: valid=%0b cnt=%0d acc=%h, required 1 2 020000",
               acc_valid, acc_count, acc);
    end
    cycle(1'b1, 17'h00009, 1'b1, 1'b1);
    cycle(1'b1, 17'h00009, 1'b1, 1'b1);
    n_vec++;
    if ({acc_valid, acc_count, acc} !== {1'b1, 5'd1, 24'h000009}) begin
      n_err++;
      $display("FAIL b2b_second: valid=%0b cnt=%0d acc=%h, required 1 1 000009",
               acc_valid, acc_count, acc);
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n      = 1'b0;
    prod_valid = 1'b0;
    prod       = '0;
    prod_last  = 1'b0;
    acc_ready  = 1'b0;
    test_reset();
    test_single();
    test_four_beats();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_bubbles();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 SHALL have parameter PROD_W, default 17: product width; matches the 8x8 multiplier product output.
REQ-002 SHALL have parameter ACC_W, default 24: accumulator width.
REQ-003 SHALL have parameter CNT_W, default 5: beat counter width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port prod_valid  input  1  upstream product beat valid.
REQ-007 SHALL have port prod_ready  output  1  block can accept a beat.
REQ-008 SHALL have port prod  input  PROD_W  unsigned product from the upstream multiplier.
REQ-009 SHALL have port prod_last  input  1  marks the final beat of a sum; qualified by prod_valid.
REQ-010 SHALL have port acc_valid  output  1  result available.
REQ-011 SHALL have port acc_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port acc  output  ACC_W  accumulated sum.
REQ-013 SHALL have port acc_count  output  CNT_W  beats in the sum.
REQ-014 SHALL have port acc_ovf  output  1  sticky overflow flag for the current sum.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 SHALL assert prod_ready in IDLE and RUN and deassert it in DONE; a beat transfers only when prod_valid & prod_ready.
REQ-017 IDLE beat SHALL load acc = zero-extended prod, acc_count = 1 and acc_ovf = 0; next state is DONE if prod_last, else RUN.
REQ-018 RUN beat SHALL form an ACC_W+1-bit sum of acc + prod; on carry-out, acc saturates to all-ones and acc_ovf is set; once set, acc stays all-ones until the next IDLE load.
REQ-019 RUN beat SHALL increment acc_count, saturating at 2^CNT_W-1; saturation does not affect acc.
REQ-020 A RUN beat with prod_last SHALL move the FSM to DONE; a RUN or IDLE cycle with no transfer SHALL hold all state.
REQ-021 acc_valid SHALL be high exactly in DONE, first in the cycle after the last beat is accepted (latency 1).
REQ-022 In DONE, acc, acc_count and acc_ovf SHALL be stable; acc_valid & acc_ready moves the FSM to IDLE, and acc_valid drops the next cycle.
REQ-023 In DONE, prod_valid SHALL be ignored, with no state change and no beat lost upstream, because prod_ready is low.
REQ-024 acc, acc_count and acc_ovf SHALL keep the last result in IDLE until the next beat is accepted.
REQ-025 prod SHALL be treated as opaque unsigned data; all PROD_W bits are used even though the bit PROD_W-1 is zero for 8x8 operands.
REQ-026 Sustained throughput SHALL be one beat per cycle in RUN; a new sum can start the cycle after the DONE handshake.

Reset
REQ-027 With rst_n low at a clock edge, SHALL set state = IDLE, acc = 0, acc_count = 0, acc_ovf = 0, acc_valid = 0 and prod_ready = 1 from the next cycle.
REQ-028 Reset in RUN or DONE SHALL discard the partial or held result with no output handshake.
REQ-029 Reset SHALL take priority over any simultaneous beat or result handshake.

Structure
REQ-030 SHALL take the FSM state encoding and default PROD_W/ACC_W/CNT_W from the shared multiplier package (mult_pkg), so the upstream multiplier wrapper and this block agree on widths.
REQ-031 SHALL be a single module; an optional leaf sat_add (ACC_W-bit saturating adder with carry-out) is the only natural sub-module.

Verification
REQ-032 Single beat: prod=0x0FE01, last=1 -> acc_valid next cycle, acc=0x00FE01, acc_count=1, acc_ovf=0.
REQ-033 Four beats of 0x0FE01, last on 4th, acc_ready=1 -> acc=0x03F804, acc_count=4, FSM back in IDLE one cycle after the handshake.
REQ-034 259 beats of 0x0FE01 -> after 258 beats acc=0xFFFD02 with no overflow; after 259, acc=0xFFFFFF, acc_ovf=1, acc_count=31.
REQ-035 Backpressure: hold acc_ready=0 for 5 cycles in DONE while prod_valid=1 -> acc is stable, prod_ready=0 and no beat is accepted; the next sum is unaffected.
REQ-036 Reset after 2 of 4 beats -> next cycle all outputs are 0, prod_ready=1; a following single beat of 0x00005 gives acc=0x000005, acc_count=1.
REQ-037 Bubbles: prod_valid toggling 1,0,1,0,1 (last on 3rd beat) with 0x00001 -> acc=3, acc_count=3.
